// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data widths, opcode and state encodings,
// and the captured request payload.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_SUB = 3'd0,
    OP_ADD = 3'd1,
    OP_OR  = 3'd2,
    OP_AND = 3'd3,
    OP_SRA = 3'd4,
    OP_ROL = 3'd5,
    OP_LTU = 3'd6,
    OP_EQ  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   sel;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU shared by both requesters.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   sel,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] rd
);

  always_comb begin
    rd = '0;
    case (alu_op_e'(sel))
      OP_SUB:  rd = rs - rt;
      OP_ADD:  rd = rs + rt;
      OP_OR:   rd = rs | rt;
      OP_AND:  rd = rs & rt;
      OP_SRA:  rd = {rt[3], rt[3:1]};
      OP_ROL:  rd = {rs[2:0], rs[3]};
      OP_LTU:  rd = {3'b101, rs < rt};
      OP_EQ:   rd = {3'b111, rs == rt};
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (gnt_cnt0/gnt_cnt1).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OP_W-1:0]     req0_sel,
  input  logic [DATA_W-1:0]   req0_rs,
  input  logic [DATA_W-1:0]   req0_rt,
  input  logic [OP_W-1:0]     req1_sel,
  input  logic [DATA_W-1:0]   req1_rs,
  input  logic [DATA_W-1:0]   req1_rt,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DATA_W-1:0]   rsp_rd,
  output logic                busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]    gnt_cnt0,
  output logic [CNT_W-1:0]    gnt_cnt1
`endif
);

  arb_state_e          state_q;
  alu_req_t            op_q;
  logic                gnt_q;
  logic                last_gnt_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rd_q;
  logic                busy_q;

  logic                accept_c;
  logic                gnt_idx_c;
  alu_req_t            req_c;
  logic [DATA_W-1:0]   alu_rd_c;

  // Grant: a lone requester wins; on contention the one not granted last time wins.
  always_comb begin
    gnt_idx_c = req_valid[1] & (~req_valid[0] | ~last_gnt_q);
    accept_c  = (state_q == ST_IDLE) && (req_valid != '0);
    req_ready = '0;
    if (accept_c) begin
      req_ready = gnt_idx_c ? 2'b10 : 2'b01;
    end
    req_c = gnt_idx_c ? '{sel: req1_sel, rs: req1_rs, rt: req1_rt}
                      : '{sel: req0_sel, rs: req0_rs, rt: req0_rt};
  end

  alu_core u_alu (
    .sel (op_q.sel),
    .rs  (op_q.rs),
    .rt  (op_q.rt),
    .rd  (alu_rd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      rsp_valid_q <= '0;
      rsp_rd_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            op_q       <= req_c;
            gnt_q      <= gnt_idx_c;
            last_gnt_q <= gnt_idx_c;
            busy_q     <= 1'b1;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_rd_q    <= alu_rd_c;
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Only the granted requester's rsp_ready can complete the handshake.
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign busy      = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0_q;
  logic [CNT_W-1:0] gnt_cnt1_q;

  // Saturating accept counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else if (accept_c) begin
      if (!gnt_idx_c && (gnt_cnt0_q != {CNT_W{1'b1}})) begin
        gnt_cnt0_q <= gnt_cnt0_q + CNT_W'(1);
      end
      if (gnt_idx_c && (gnt_cnt1_q != {CNT_W{1'b1}})) begin
        gnt_cnt1_q <= gnt_cnt1_q + CNT_W'(1);
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus directed and random traffic.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [2:0] req0_sel = 3'd0, req1_sel = 3'd0;
  logic [3:0] req0_rs = 4'd0, req0_rt = 4'd0, req1_rs = 4'd0, req1_rt = 4'd0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [3:0] rsp_rd;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_sel  (req0_sel),
    .req0_rs   (req0_rs),
    .req0_rt   (req0_rt),
    .req1_sel  (req1_sel),
    .req1_rs   (req1_rs),
    .req1_rt   (req1_rt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd),
    .busy      (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written with integer arithmetic.
  function automatic logic [3:0] alu_model(input int sel, input int rs, input int rt);
    int r;
    case (sel)
      0: r = (rs - rt + 16) % 16;
      1: r = (rs + rt) % 16;
      2: r = rs | rt;
      3: r = rs & rt;
      4: r = (rt / 2) + (rt & 8);
      5: r = ((rs * 2) % 16) + (rs / 8);
      6: r = 10 + ((rs < rt) ? 1 : 0);
      default: r = 14 + ((rs == rt) ? 1 : 0);
    endcase
    return 4'(r);
  endfunction

  // Transaction model: one operation in flight; response visible from the second cycle after accept.
  bit   m_busy;
  int   m_age;
  int   m_gnt;
  int   m_last;
  logic [3:0] m_rd;
  int   m_cnt0, m_cnt1;

  always @(negedge clk) begin : cmp
    int g;
    logic [1:0] e_ready;
    logic [1:0] e_valid;
    if (!rst_n) begin
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_rsp_valid", 8'(rsp_valid), 8'h0);
      chk("rst_rsp_rd", 8'(rsp_rd), 8'h0);
      m_busy = 0; m_age = 0; m_gnt = 0; m_last = 1; m_rd = 4'h0;
      m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if (req_valid == 2'b11) g = (m_last == 1) ? 0 : 1;
      else                    g = req_valid[1] ? 1 : 0;
      e_ready = (!m_busy && req_valid != 2'b00) ? 2'(1 << g) : 2'b00;
      e_valid = (m_busy && m_age >= 1) ? 2'(1 << m_gnt) : 2'b00;
      chk("req_ready", 8'(req_ready), 8'(e_ready));
      chk("rsp_valid", 8'(rsp_valid), 8'(e_valid));
      chk("busy", 8'(busy), 8'(m_busy));
      if (e_valid != 2'b00) chk("rsp_rd", 8'(rsp_rd), 8'(m_rd));
`ifdef ALU_ARB_STATS_EN
      chk("gnt_cnt0", gnt_cnt0, 8'(m_cnt0));
      chk("gnt_cnt1", gnt_cnt1, 8'(m_cnt1));
`endif
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          m_busy = 1; m_age = 0; m_gnt = g; m_last = g;
          m_rd = (g == 1) ? alu_model(int'(req1_sel), int'(req1_rs), int'(req1_rt))
                          : alu_model(int'(req0_sel), int'(req0_rs), int'(req0_rt));
          if (g == 0 && m_cnt0 < 255) m_cnt0++;
          if (g == 1 && m_cnt1 < 255) m_cnt1++;
        end
      end else if (m_age >= 1 && rsp_ready[m_gnt]) begin
        m_busy = 0;
      end else begin
        m_age = 1;
      end
    end
  end

  task automatic drive(input int who, input logic [2:0] sel, input logic [3:0] rs, input logic [3:0] rt);
    if (who == 0) begin req0_sel = sel; req0_rs = rs; req0_rt = rt; end
    else          begin req1_sel = sel; req1_rs = rs; req1_rt = rt; end
    req_valid[who] = 1'b1;
  endtask

  task automatic wait_accept(input int who, input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[who];
    end
    if (!ok) chk({name, "_accept_timeout"}, 8'h0, 8'h1);
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
  endtask

  task automatic wait_rsp(input int who, input logic [3:0] exp, input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid[who];
    end
    if (!ok) chk({name, "_rsp_timeout"}, 8'h0, 8'h1);
    else     chk({name, "_rd"}, 8'(rsp_rd), 8'(exp));
  endtask

  // Single op with exact latency: no response in EXEC, response in the following cycle.
  task automatic op_check(input int who, input logic [2:0] sel, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] exp, input string name);
    drive(who, sel, rs, rt);
    wait_accept(who, name);
    @(negedge clk);
    chk({name, "_exec_valid"}, 8'(rsp_valid), 8'h0);
    chk({name, "_exec_busy"}, 8'(busy), 8'h1);
    @(negedge clk);
    chk({name, "_resp_valid"}, 8'(rsp_valid), (who == 0) ? 8'h1 : 8'h2);
    chk({name, "_rd"}, 8'(rsp_rd), 8'(exp));
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [2:0] sw_sel [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
  logic [3:0] sw_exp [5] = '{4'hB, 4'h8, 4'hC, 4'h5, 4'hE};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    op_check(0, 3'd1, 4'h9, 4'h8, 4'h1, "add_9_8");

    // Contention straight from reset: requester 0 first, then requester 1.
    @(posedge clk); #1;
    apply_reset();
    drive(0, 3'd0, 4'h3, 4'h5);
    drive(1, 3'd6, 4'h3, 4'h5);
    @(negedge clk);
    chk("contend_ready", 8'(req_ready), 8'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, 4'hE, "contend_r0");
    @(posedge clk); #1;
    wait_accept(1, "contend_r1");
    wait_rsp(1, 4'hB, "contend_r1");
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) op_check(i % 2, sw_sel[i], 4'hA, 4'h9, sw_exp[i], "sweep");

    // Stall in RESP; the other requester's rsp_ready must not complete it.
    rsp_ready = 2'b10;
    drive(0, 3'd1, 4'h2, 4'h3);
    wait_accept(0, "stall");
    drive(1, 3'd7, 4'h4, 4'h4);
    wait_rsp(0, 4'h5, "stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 8'(rsp_valid), 8'h1);
      chk("stall_rd", 8'(rsp_rd), 8'h5);
      chk("stall_ready", 8'(req_ready), 8'h0);
      chk("stall_busy", 8'(busy), 8'h1);
    end
    @(posedge clk); #1 rsp_ready = 2'b01;
    @(posedge clk); #1 rsp_ready = 2'b11;
    wait_accept(1, "after_stall");
    wait_rsp(1, 4'hF, "after_stall");
    @(posedge clk); #1;

    // Reset in EXEC drops the operation immediately.
    drive(0, 3'd1, 4'h6, 4'h6);
    wait_accept(0, "rst_exec");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec_valid", 8'(rsp_valid), 8'h0);
    chk("rst_exec_busy", 8'(busy), 8'h0);
    chk("rst_exec_rd", 8'(rsp_rd), 8'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 8'(rsp_valid), 8'h0);
    end
    @(posedge clk); #1;

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req0_sel = 3'($urandom); req0_rs = 4'($urandom); req0_rt = 4'($urandom);
      req1_sel = 3'($urandom); req1_rs = 4'($urandom); req1_rt = 4'($urandom);
      rsp_ready = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (5) @(posedge clk);
    #1;

`ifdef ALU_ARB_STATS_EN
    apply_reset();
    req_valid = 2'b10;
    for (int i = 0; i < 950; i++) begin
      req1_sel = 3'($urandom); req1_rs = 4'($urandom); req1_rt = 4'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stats_cnt1_sat", gnt_cnt1, 8'hFF);
    chk("stats_cnt0_zero", gnt_cnt0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
